// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcodes, beat-count helpers and counter sizing shared by the source shrinker.
package tl_ul_pkg;

  localparam int unsigned BeatCntW = 3;
  localparam int unsigned BeatW    = BeatCntW + 1;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  // Sizes above 6 do not fit the counter and are not supported.
  function automatic logic [BeatW-1:0] beats(input logic [2:0] size);
    if (size <= 3'd3) return BeatW'(1);
    return BeatW'(1) << (size - 3'd3);
  endfunction

  function automatic logic a_has_data(input logic [2:0] opcode);
    return ~opcode[2];
  endfunction

  function automatic logic d_has_data(input logic [2:0] opcode);
    return opcode[0];
  endfunction

  // Remaining beats after the first one, as loaded into a beat counter.
  function automatic logic [BeatCntW-1:0] msg_len_a(input logic [2:0] opcode,
                                                    input logic [2:0] size);
    if (!a_has_data(opcode)) return '0;
    return BeatCntW'(beats(size) - BeatW'(1));
  endfunction

  function automatic logic [BeatCntW-1:0] msg_len_d(input logic [2:0] opcode,
                                                    input logic [2:0] size);
    if (!d_has_data(opcode)) return '0;
    return BeatCntW'(beats(size) - BeatW'(1));
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Per-channel beat tracker: loads the remaining beat count on a first-beat fire and
// counts down on later fires, flagging the first and last beat of the current message.
module tl_beat_counter
  import tl_ul_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                fire,
  input  logic [BeatCntW-1:0] len,
  output logic                first,
  output logic                last
);

  logic [BeatCntW-1:0] cnt_q, cnt_d;

  assign first = (cnt_q == '0);
  // len only matters on the first beat; afterwards the count itself says when we end
  assign last  = first ? (len == '0) : (cnt_q == BeatCntW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      cnt_d = first ? len : cnt_q - BeatCntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tl_source_shrinker.sv
// TileLink-UL source shrinker: maps client source IDs onto a small manager-side ID pool,
// restores them on D, and stalls A while every manager-side ID is in flight.
module tl_source_shrinker
  import tl_ul_pkg::*;
#(
  parameter int unsigned IN_SOURCE_W  = 4,
  parameter int unsigned OUT_IDS      = 4,
  parameter int unsigned OUT_SOURCE_W = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 64
) (
  input  logic                    clock,
  input  logic                    reset,

  output logic                    auto_in_a_ready,
  input  logic                    auto_in_a_valid,
  input  logic [2:0]              auto_in_a_bits_opcode,
  input  logic [2:0]              auto_in_a_bits_param,
  input  logic [2:0]              auto_in_a_bits_size,
  input  logic [IN_SOURCE_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]       auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0]     auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]       auto_in_a_bits_data,
  input  logic                    auto_in_a_bits_corrupt,

  input  logic                    auto_in_d_ready,
  output logic                    auto_in_d_valid,
  output logic [2:0]              auto_in_d_bits_opcode,
  output logic [2:0]              auto_in_d_bits_size,
  output logic [IN_SOURCE_W-1:0]  auto_in_d_bits_source,
  output logic                    auto_in_d_bits_denied,
  output logic [DATA_W-1:0]       auto_in_d_bits_data,
  output logic                    auto_in_d_bits_corrupt,

  input  logic                    auto_out_a_ready,
  output logic                    auto_out_a_valid,
  output logic [2:0]              auto_out_a_bits_opcode,
  output logic [2:0]              auto_out_a_bits_param,
  output logic [2:0]              auto_out_a_bits_size,
  output logic [OUT_SOURCE_W-1:0] auto_out_a_bits_source,
  output logic [ADDR_W-1:0]       auto_out_a_bits_address,
  output logic [DATA_W/8-1:0]     auto_out_a_bits_mask,
  output logic [DATA_W-1:0]       auto_out_a_bits_data,
  output logic                    auto_out_a_bits_corrupt,

  output logic                    auto_out_d_ready,
  input  logic                    auto_out_d_valid,
  input  logic [2:0]              auto_out_d_bits_opcode,
  input  logic [2:0]              auto_out_d_bits_size,
  input  logic [OUT_SOURCE_W-1:0] auto_out_d_bits_source,
  input  logic                    auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]       auto_out_d_bits_data,
  input  logic                    auto_out_d_bits_corrupt
);

  logic [OUT_IDS-1:0]      free_q, free_d;
  logic [IN_SOURCE_W-1:0]  src_table_q [OUT_IDS];
  logic [OUT_SOURCE_W-1:0] held_id_q;
  logic [OUT_SOURCE_W-1:0] alloc_id;
  logic                    a_first, a_last, a_gate, a_fire;
  logic                    d_first_unused, d_last, d_fire;
  logic [BeatCntW-1:0]     a_len, d_len;

  // Lowest-indexed free ID from the registered bitmap; IDs freed this cycle are not seen.
  always_comb begin
    alloc_id = '0;
    for (int i = int'(OUT_IDS) - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_id = OUT_SOURCE_W'(i);
    end
  end

  // Later beats of a burst already own an ID, so only first beats can be throttled.
  assign a_gate = a_first ? (|free_q) : 1'b1;
  assign a_fire = auto_in_a_valid & auto_out_a_ready & a_gate;
  assign d_fire = auto_out_d_valid & auto_in_d_ready;

  assign a_len = msg_len_a(auto_in_a_bits_opcode, auto_in_a_bits_size);
  assign d_len = msg_len_d(auto_out_d_bits_opcode, auto_out_d_bits_size);

  tl_beat_counter u_a_cnt (
    .clock (clock),
    .reset (reset),
    .fire  (a_fire),
    .len   (a_len),
    .first (a_first),
    .last  (a_last)
  );

  tl_beat_counter u_d_cnt (
    .clock (clock),
    .reset (reset),
    .fire  (d_fire),
    .len   (d_len),
    .first (d_first_unused),
    .last  (d_last)
  );

  // A channel
  assign auto_out_a_valid        = auto_in_a_valid & a_gate;
  assign auto_in_a_ready         = auto_out_a_ready & a_gate;
  assign auto_out_a_bits_source  = a_first ? alloc_id : held_id_q;
  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
  assign auto_out_a_bits_data    = auto_in_a_bits_data;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

  // D channel
  assign auto_in_d_valid        = auto_out_d_valid;
  assign auto_out_d_ready       = auto_in_d_ready;
  assign auto_in_d_bits_source  = src_table_q[auto_out_d_bits_source];
  assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
  assign auto_in_d_bits_size    = auto_out_d_bits_size;
  assign auto_in_d_bits_denied  = auto_out_d_bits_denied;
  assign auto_in_d_bits_data    = auto_out_d_bits_data;
  assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;

  always_comb begin
    free_d = free_q;
    if (a_fire && a_first) free_d[alloc_id] = 1'b0;
    if (d_fire && d_last)  free_d[auto_out_d_bits_source] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_q    <= '1;
      held_id_q <= '0;
      for (int i = 0; i < int'(OUT_IDS); i++) begin
        src_table_q[i] <= '0;
      end
    end else begin
      free_q <= free_d;
      if (a_fire && a_first) begin
        src_table_q[alloc_id] <= auto_in_a_bits_source;
        if (!a_last) held_id_q <= alloc_id;
      end
    end
  end

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Self-checking bench for tl_source_shrinker: directed scenarios plus a randomized mix,
// checked against an in-flight ID model (lowest free ID, stored client source per ID).
module tb_tl_source_shrinker;
  import tl_ul_pkg::*;

  localparam int unsigned IN_SOURCE_W  = 4;
  localparam int unsigned OUT_IDS      = 4;
  localparam int unsigned OUT_SOURCE_W = 2;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic                    auto_in_a_ready, auto_in_a_valid;
  logic [2:0]              auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size;
  logic [IN_SOURCE_W-1:0]  auto_in_a_bits_source;
  logic [ADDR_W-1:0]       auto_in_a_bits_address;
  logic [DATA_W/8-1:0]     auto_in_a_bits_mask;
  logic [DATA_W-1:0]       auto_in_a_bits_data;
  logic                    auto_in_a_bits_corrupt;
  logic                    auto_in_d_ready, auto_in_d_valid;
  logic [2:0]              auto_in_d_bits_opcode, auto_in_d_bits_size;
  logic [IN_SOURCE_W-1:0]  auto_in_d_bits_source;
  logic                    auto_in_d_bits_denied, auto_in_d_bits_corrupt;
  logic [DATA_W-1:0]       auto_in_d_bits_data;
  logic                    auto_out_a_ready, auto_out_a_valid;
  logic [2:0]              auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size;
  logic [OUT_SOURCE_W-1:0] auto_out_a_bits_source;
  logic [ADDR_W-1:0]       auto_out_a_bits_address;
  logic [DATA_W/8-1:0]     auto_out_a_bits_mask;
  logic [DATA_W-1:0]       auto_out_a_bits_data;
  logic                    auto_out_a_bits_corrupt;
  logic                    auto_out_d_ready, auto_out_d_valid;
  logic [2:0]              auto_out_d_bits_opcode, auto_out_d_bits_size;
  logic [OUT_SOURCE_W-1:0] auto_out_d_bits_source;
  logic                    auto_out_d_bits_denied, auto_out_d_bits_corrupt;
  logic [DATA_W-1:0]       auto_out_d_bits_data;

  tl_source_shrinker #(
    .IN_SOURCE_W  (IN_SOURCE_W),
    .OUT_IDS      (OUT_IDS),
    .OUT_SOURCE_W (OUT_SOURCE_W),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_ready         (auto_in_a_ready),
    .auto_in_a_valid         (auto_in_a_valid),
    .auto_in_a_bits_opcode   (auto_in_a_bits_opcode),
    .auto_in_a_bits_param    (auto_in_a_bits_param),
    .auto_in_a_bits_size     (auto_in_a_bits_size),
    .auto_in_a_bits_source   (auto_in_a_bits_source),
    .auto_in_a_bits_address  (auto_in_a_bits_address),
    .auto_in_a_bits_mask     (auto_in_a_bits_mask),
    .auto_in_a_bits_data     (auto_in_a_bits_data),
    .auto_in_a_bits_corrupt  (auto_in_a_bits_corrupt),
    .auto_in_d_ready         (auto_in_d_ready),
    .auto_in_d_valid         (auto_in_d_valid),
    .auto_in_d_bits_opcode   (auto_in_d_bits_opcode),
    .auto_in_d_bits_size     (auto_in_d_bits_size),
    .auto_in_d_bits_source   (auto_in_d_bits_source),
    .auto_in_d_bits_denied   (auto_in_d_bits_denied),
    .auto_in_d_bits_data     (auto_in_d_bits_data),
    .auto_in_d_bits_corrupt  (auto_in_d_bits_corrupt),
    .auto_out_a_ready        (auto_out_a_ready),
    .auto_out_a_valid        (auto_out_a_valid),
    .auto_out_a_bits_opcode  (auto_out_a_bits_opcode),
    .auto_out_a_bits_param   (auto_out_a_bits_param),
    .auto_out_a_bits_size    (auto_out_a_bits_size),
    .auto_out_a_bits_source  (auto_out_a_bits_source),
    .auto_out_a_bits_address (auto_out_a_bits_address),
    .auto_out_a_bits_mask    (auto_out_a_bits_mask),
    .auto_out_a_bits_data    (auto_out_a_bits_data),
    .auto_out_a_bits_corrupt (auto_out_a_bits_corrupt),
    .auto_out_d_ready        (auto_out_d_ready),
    .auto_out_d_valid        (auto_out_d_valid),
    .auto_out_d_bits_opcode  (auto_out_d_bits_opcode),
    .auto_out_d_bits_size    (auto_out_d_bits_size),
    .auto_out_d_bits_source  (auto_out_d_bits_source),
    .auto_out_d_bits_denied  (auto_out_d_bits_denied),
    .auto_out_d_bits_data    (auto_out_d_bits_data),
    .auto_out_d_bits_corrupt (auto_out_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which manager IDs are in flight and whose client source each carries.
  bit                     m_busy [OUT_IDS];
  logic [IN_SOURCE_W-1:0] m_src  [OUT_IDS];

  function automatic int m_lowest_free();
    for (int i = 0; i < int'(OUT_IDS); i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int tb_beats(input int sz);
    return (sz <= 3) ? 1 : (1 << (sz - 3));
  endfunction

  task automatic idle_inputs();
    auto_in_a_valid = 1'b0;        auto_in_a_bits_opcode = OpGet;
    auto_in_a_bits_param = '0;     auto_in_a_bits_size = 3'd3;
    auto_in_a_bits_source = '0;    auto_in_a_bits_address = '0;
    auto_in_a_bits_mask = '1;      auto_in_a_bits_data = '0;
    auto_in_a_bits_corrupt = 1'b0; auto_out_a_ready = 1'b1;
    auto_in_d_ready = 1'b1;        auto_out_d_valid = 1'b0;
    auto_out_d_bits_opcode = OpAccessAck; auto_out_d_bits_size = 3'd3;
    auto_out_d_bits_source = '0;   auto_out_d_bits_denied = 1'b0;
    auto_out_d_bits_data = '0;     auto_out_d_bits_corrupt = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
    auto_in_a_valid = 1'b1;       auto_in_a_bits_opcode = op;
    auto_in_a_bits_size = sz;     auto_in_a_bits_source = src;
    auto_in_a_bits_address = $urandom; auto_in_a_bits_data = {$urandom, $urandom};
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] oid);
    auto_out_d_valid = 1'b1;      auto_out_d_bits_opcode = op;
    auto_out_d_bits_size = sz;    auto_out_d_bits_source = oid;
    auto_out_d_bits_data = {$urandom, $urandom};
  endtask

  // Sends one whole A message; reports the out ID of the first beat and whether it held.
  task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                        input bit toggle, output logic [1:0] id, output bit stable,
                        output bit ok);
    int nb, done;
    nb = (op[2] == 1'b0) ? tb_beats(int'(sz)) : 1;
    done = 0; stable = 1'b1; id = '0;
    for (int cyc = 0; cyc < 200 && done < nb; cyc++) begin
      @(negedge clock);
      drive_a(op, sz, src);
      auto_out_a_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (auto_out_a_valid && auto_in_a_ready) begin
        if (done == 0) id = auto_out_a_bits_source;
        else if (auto_out_a_bits_source !== id) stable = 1'b0;
        done++;
      end
    end
    ok = (done == nb);
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0; auto_out_a_ready = 1'b1;
  endtask

  // Sends one whole D message for a manager ID; reports the restored client source.
  task automatic send_d(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] oid,
                        input bit toggle, output logic [3:0] src, output bit stable,
                        output bit ok);
    int nb, done;
    nb = op[0] ? tb_beats(int'(sz)) : 1;
    done = 0; stable = 1'b1; src = '0;
    for (int cyc = 0; cyc < 200 && done < nb; cyc++) begin
      @(negedge clock);
      drive_d(op, sz, oid);
      auto_in_d_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (auto_in_d_valid && auto_out_d_ready) begin
        if (done == 0) src = auto_in_d_bits_source;
        else if (auto_in_d_bits_source !== src) stable = 1'b0;
        done++;
      end
    end
    ok = (done == nb);
    @(posedge clock); #1;
    auto_out_d_valid = 1'b0; auto_in_d_ready = 1'b1;
  endtask

  task automatic drain_ids();
    logic [3:0] src; bit stable, ok;
    for (int i = 0; i < int'(OUT_IDS); i++) begin
      if (m_busy[i]) begin
        send_d(OpAccessAck, 3'd2, 2'(i), 1'b0, src, stable, ok);
        n_checks++;
        if (!ok || src !== m_src[i]) begin
          n_fail++;
          $display("FAIL drain_src[%0d]: got %0h want %0h (ok=%0d)", i, src, m_src[i], ok);
        end
        m_busy[i] = 1'b0;
      end
    end
  endtask

  task automatic fill_ids();
    logic [1:0] id; bit stable, ok; logic [3:0] src; int exp;
    while (m_lowest_free() >= 0) begin
      exp = m_lowest_free();
      src = 4'($urandom);
      send_a(OpGet, 3'd3, src, 1'b0, id, stable, ok);
      n_checks++;
      if (!ok || id !== 2'(exp)) begin
        n_fail++;
        $display("FAIL fill_id: got %0d want %0d (ok=%0d)", id, exp, ok);
      end
      m_busy[exp] = 1'b1; m_src[exp] = src;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    drive_a(OpGet, 3'd3, 4'hA);
    auto_in_a_bits_address = 32'h1234_5678;
    auto_out_d_bits_source = 2'd2;
    #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b1 || auto_out_a_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_gate_open: got ready=%0b valid=%0b want 1/1",
               auto_in_a_ready, auto_out_a_valid);
    end
    n_checks++;
    if (auto_out_a_bits_source !== 2'd0 || auto_out_a_bits_address !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL reset_a_fields: got src=%0d addr=%0h want 0/12345678",
               auto_out_a_bits_source, auto_out_a_bits_address);
    end
    auto_out_a_ready = 1'b0; #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_follow: got %0b want 0", auto_in_a_ready);
    end
    n_checks++;
    if (auto_in_d_bits_source !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_table: got %0h want 0", auto_in_d_bits_source);
    end
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < int'(OUT_IDS); i++) begin m_busy[i] = 1'b0; m_src[i] = '0; end
  endtask

  task automatic test_single_get();
    logic [31:0] addr; logic [63:0] dat;
    @(negedge clock);
    drive_a(OpGet, 3'd3, 4'd9);
    addr = auto_in_a_bits_address;
    #1;
    n_checks++;
    if (auto_out_a_valid !== 1'b1 || auto_in_a_ready !== 1'b1 || auto_out_a_bits_source !== 2'd0
        || auto_out_a_bits_address !== addr || auto_out_a_bits_opcode !== OpGet) begin
      n_fail++;
      $display("FAIL single_get_a: got v=%0b r=%0b src=%0d addr=%0h want 1/1/0/%0h",
               auto_out_a_valid, auto_in_a_ready, auto_out_a_bits_source,
               auto_out_a_bits_address, addr);
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0;
    m_busy[0] = 1'b1; m_src[0] = 4'd9;
    // Response and a new Get in the same cycle: ID 0 is not reusable yet.
    @(negedge clock);
    drive_d(OpAccessAckData, 3'd3, 2'd0);
    dat = auto_out_d_bits_data;
    drive_a(OpGet, 3'd3, 4'd2);
    #1;
    n_checks++;
    if (auto_in_d_valid !== 1'b1 || auto_in_d_bits_source !== 4'd9
        || auto_in_d_bits_data !== dat || auto_in_d_bits_opcode !== OpAccessAckData) begin
      n_fail++;
      $display("FAIL single_get_d: got v=%0b src=%0h data=%0h want 1/9/%0h",
               auto_in_d_valid, auto_in_d_bits_source, auto_in_d_bits_data, dat);
    end
    n_checks++;
    if (auto_out_a_bits_source !== 2'd1) begin
      n_fail++;
      $display("FAIL single_get_stale_free: got %0d want 1", auto_out_a_bits_source);
    end
    @(posedge clock); #1;
    auto_out_d_valid = 1'b0; auto_in_a_valid = 1'b0;
    m_busy[0] = 1'b0; m_busy[1] = 1'b1; m_src[1] = 4'd2;
    @(negedge clock);
    drive_a(OpGet, 3'd3, 4'd3);
    #1;
    n_checks++;
    if (auto_out_a_bits_source !== 2'd0 || auto_in_a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_get_freed: got src=%0d r=%0b want 0/1",
               auto_out_a_bits_source, auto_in_a_ready);
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0;
    m_busy[0] = 1'b1; m_src[0] = 4'd3;
    drain_ids();
  endtask

  task automatic test_fill_stall();
    logic [3:0] srcs [4];
    logic [1:0] id; bit stable, ok;
    srcs = '{4'd1, 4'd5, 4'd7, 4'd12};
    for (int i = 0; i < 4; i++) begin
      send_a(OpGet, 3'd2, srcs[i], 1'b0, id, stable, ok);
      n_checks++;
      if (!ok || id !== 2'(i)) begin
        n_fail++;
        $display("FAIL fill_stall_id[%0d]: got %0d want %0d (ok=%0d)", i, id, i, ok);
      end
      m_busy[i] = 1'b1; m_src[i] = srcs[i];
    end
    @(negedge clock);
    drive_a(OpGet, 3'd3, 4'd3);
    auto_out_a_ready = 1'b1;
    #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b0 || auto_out_a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_stall_full: got r=%0b v=%0b want 0/0",
               auto_in_a_ready, auto_out_a_valid);
    end
    @(negedge clock);
    drive_d(OpAccessAckData, 3'd0, 2'd2);
    #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b0 || auto_in_d_bits_source !== 4'd7) begin
      n_fail++;
      $display("FAIL fill_stall_free_cycle: got r=%0b dsrc=%0h want 0/7",
               auto_in_a_ready, auto_in_d_bits_source);
    end
    @(posedge clock); #1;
    auto_out_d_valid = 1'b0; m_busy[2] = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b1 || auto_out_a_valid !== 1'b1 || auto_out_a_bits_source !== 2'd2)
    begin
      n_fail++;
      $display("FAIL fill_stall_release: got r=%0b v=%0b src=%0d want 1/1/2",
               auto_in_a_ready, auto_out_a_valid, auto_out_a_bits_source);
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0; m_busy[2] = 1'b1; m_src[2] = 4'd3;
    drain_ids();
  endtask

  task automatic test_burst_put();
    int exp, done;
    logic [1:0] id; logic [3:0] src; bit stable, ok;
    exp = m_lowest_free();
    done = 0;
    for (int cyc = 0; cyc < 100 && done < 8; cyc++) begin
      @(negedge clock);
      drive_a(OpPutFull, 3'd6, 4'd4);
      auto_out_a_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (auto_out_a_valid !== 1'b1 || auto_in_a_ready !== auto_out_a_ready
          || auto_out_a_bits_source !== 2'(exp) || auto_out_a_bits_data !== auto_in_a_bits_data)
      begin
        n_fail++;
        $display("FAIL burst_beat[%0d]: got v=%0b r=%0b src=%0d want 1/%0b/%0d", done,
                 auto_out_a_valid, auto_in_a_ready, auto_out_a_bits_source, auto_out_a_ready,
                 exp);
      end
      if (auto_out_a_ready) done++;
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0; auto_out_a_ready = 1'b1;
    n_checks++;
    if (done != 8) begin
      n_fail++;
      $display("FAIL burst_beats: got %0d want 8", done);
    end
    m_busy[exp] = 1'b1; m_src[exp] = 4'd4;
    // Only one ID may have been consumed by the whole burst.
    exp = m_lowest_free();
    send_a(OpGet, 3'd3, 4'd6, 1'b0, id, stable, ok);
    n_checks++;
    if (!ok || id !== 2'(exp)) begin
      n_fail++;
      $display("FAIL burst_next_id: got %0d want %0d (ok=%0d)", id, exp, ok);
    end
    m_busy[exp] = 1'b1; m_src[exp] = 4'd6;
    send_d(OpAccessAck, 3'd6, 2'd0, 1'b0, src, stable, ok);
    n_checks++;
    if (!ok || src !== 4'd4) begin
      n_fail++;
      $display("FAIL burst_ack_src: got %0h want 4 (ok=%0d)", src, ok);
    end
    m_busy[0] = 1'b0;
    send_a(OpGet, 3'd3, 4'd8, 1'b0, id, stable, ok);
    n_checks++;
    if (!ok || id !== 2'd0) begin
      n_fail++;
      $display("FAIL burst_ack_frees: got %0d want 0 (ok=%0d)", id, ok);
    end
    m_busy[0] = 1'b1; m_src[0] = 4'd8;
    drain_ids();
  endtask

  task automatic test_multibeat_d();
    logic [1:0] id; bit stable, ok; int done;
    send_a(OpGet, 3'd5, 4'd11, 1'b0, id, stable, ok);
    n_checks++;
    if (!ok || id !== 2'd0) begin
      n_fail++;
      $display("FAIL mbd_get_id: got %0d want 0 (ok=%0d)", id, ok);
    end
    m_busy[0] = 1'b1; m_src[0] = 4'd11;
    fill_ids();
    done = 0;
    for (int cyc = 0; cyc < 100 && done < 4; cyc++) begin
      @(negedge clock);
      drive_d(OpAccessAckData, 3'd5, 2'd0);
      drive_a(OpGet, 3'd3, 4'd13);
      auto_in_d_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (auto_in_a_ready !== 1'b0 || auto_in_d_bits_source !== 4'd11
          || auto_out_d_ready !== auto_in_d_ready) begin
        n_fail++;
        $display("FAIL mbd_busy[%0d]: got r=%0b dsrc=%0h want 0/b", done, auto_in_a_ready,
                 auto_in_d_bits_source);
      end
      if (auto_in_d_ready) done++;
    end
    @(posedge clock); #1;
    auto_out_d_valid = 1'b0; auto_in_d_ready = 1'b1; m_busy[0] = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (done != 4 || auto_in_a_ready !== 1'b1 || auto_out_a_bits_source !== 2'd0) begin
      n_fail++;
      $display("FAIL mbd_release: got beats=%0d r=%0b src=%0d want 4/1/0", done,
               auto_in_a_ready, auto_out_a_bits_source);
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0; m_busy[0] = 1'b1; m_src[0] = 4'd13;
    drain_ids();
  endtask

  task automatic test_same_cycle_free();
    logic [3:0] s1;
    fill_ids();
    s1 = m_src[1];
    @(negedge clock);
    drive_a(OpGet, 3'd3, 4'd14);
    drive_d(OpAccessAck, 3'd2, 2'd1);
    #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b0 || auto_out_a_valid !== 1'b0 || auto_in_d_bits_source !== s1)
    begin
      n_fail++;
      $display("FAIL same_cycle_stall: got r=%0b v=%0b dsrc=%0h want 0/0/%0h",
               auto_in_a_ready, auto_out_a_valid, auto_in_d_bits_source, s1);
    end
    @(posedge clock); #1;
    auto_out_d_valid = 1'b0; m_busy[1] = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b1 || auto_out_a_bits_source !== 2'(m_lowest_free())) begin
      n_fail++;
      $display("FAIL same_cycle_next: got r=%0b src=%0d want 1/%0d", auto_in_a_ready,
               auto_out_a_bits_source, m_lowest_free());
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0; m_busy[1] = 1'b1; m_src[1] = 4'd14;
    drain_ids();
  endtask

  task automatic test_reset_mid();
    logic [1:0] id; bit stable, ok; int done;
    for (int i = 0; i < 3; i++) begin
      send_a(OpGet, 3'd3, 4'(i + 5), 1'b0, id, stable, ok);
      m_busy[i] = 1'b1; m_src[i] = 4'(i + 5);
    end
    done = 0;
    for (int cyc = 0; cyc < 20 && done < 3; cyc++) begin
      @(negedge clock);
      drive_a(OpPutFull, 3'd6, 4'd15);
      #1;
      if (auto_in_a_ready) done++;
      @(posedge clock);
    end
    @(negedge clock);
    reset = 1'b1;
    auto_out_a_ready = 1'b1; auto_out_d_bits_source = 2'd1;
    #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b1 || auto_out_a_bits_source !== 2'd0
        || auto_in_d_bits_source !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got r=%0b src=%0d dsrc=%0h want 1/0/0", auto_in_a_ready,
               auto_out_a_bits_source, auto_in_d_bits_source);
    end
    auto_out_a_ready = 1'b0; #1;
    n_checks++;
    if (auto_in_a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %0b want 0", auto_in_a_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < int'(OUT_IDS); i++) m_busy[i] = 1'b0;
    fill_ids();
    drain_ids();
  endtask

  task automatic test_random();
    logic [1:0] id; logic [3:0] src; bit stable, ok;
    logic [2:0] op, sz; int lf, pick, nbusy;
    for (int it = 0; it < 80; it++) begin
      lf = m_lowest_free();
      nbusy = 0;
      for (int i = 0; i < int'(OUT_IDS); i++) nbusy += int'(m_busy[i]);
      sz = 3'($urandom_range(0, 6));
      if (lf >= 0 && (nbusy == 0 || $urandom_range(0, 1) == 1)) begin
        case ($urandom_range(0, 2))
          0: op = OpGet;
          1: op = OpPutFull;
          default: op = OpPutPartial;
        endcase
        src = 4'($urandom);
        send_a(op, sz, src, 1'b1, id, stable, ok);
        n_checks++;
        if (!ok || !stable || id !== 2'(lf)) begin
          n_fail++;
          $display("FAIL random_a[%0d]: got id=%0d stable=%0d ok=%0d want %0d", it, id, stable,
                   ok, lf);
        end
        m_busy[lf] = 1'b1; m_src[lf] = src;
      end else if (lf < 0 && $urandom_range(0, 3) == 0) begin
        @(negedge clock);
        drive_a(OpGet, 3'd3, 4'($urandom));
        auto_out_a_ready = 1'b1;
        #1;
        n_checks++;
        if (auto_in_a_ready !== 1'b0 || auto_out_a_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL random_stall[%0d]: got r=%0b v=%0b want 0/0", it, auto_in_a_ready,
                   auto_out_a_valid);
        end
        @(posedge clock); #1;
        auto_in_a_valid = 1'b0;
      end else begin
        pick = int'($urandom_range(0, OUT_IDS - 1));
        while (!m_busy[pick]) pick = (pick + 1) % int'(OUT_IDS);
        op = ($urandom_range(0, 1) == 1) ? OpAccessAckData : OpAccessAck;
        send_d(op, sz, 2'(pick), 1'b1, src, stable, ok);
        n_checks++;
        if (!ok || !stable || src !== m_src[pick]) begin
          n_fail++;
          $display("FAIL random_d[%0d]: got src=%0h stable=%0d ok=%0d want %0h", it, src,
                   stable, ok, m_src[pick]);
        end
        m_busy[pick] = 1'b0;
      end
    end
    drain_ids();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_get();
    test_fill_stall();
    test_burst_put();
    test_multibeat_d();
    test_same_cycle_free();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
